// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf16_pkg
// Purpose  : BF16 type, special encodings and the flush-to-zero helper.
// Revision : 1.0
// ============================================================================
package bf16_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t CANONICAL_NAN = 16'h7FC0;
  localparam bf16_t POS_INF       = 16'h7F80;
  localparam bf16_t NEG_INF       = 16'hFF80;
  localparam int    BF16_BIAS     = 127;

  // Denormal inputs collapse to a zero that keeps its sign.
  function automatic bf16_t ftz(input bf16_t x);
    ftz = (x[14:7] == 8'h00) ? {x[15], 15'h0000} : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf16_add_rne.sv
`default_nettype none
// ============================================================================
// Module   : bf16_add_rne
// Purpose  : Combinational BF16 adder with FTZ and RNE/truncate rounding.
// Revision : 1.0
// ============================================================================
module bf16_add_rne
  import bf16_pkg::*;
#(
  parameter int ROUND_RNE = 1
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  bf16_t             w_a, w_b, w_big, w_small;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [7:0]        w_diff;
  logic [10:0]       w_sm_ext, w_sticky_mask;
  logic [11:0]       w_big_al, w_sm_al, w_mag;
  logic              w_found, w_rnd;
  logic [3:0]        w_lz;
  logic signed [9:0] w_exp;
  logic [14:0]       w_body;

  always_comb begin
    w_a      = ftz(a);
    w_b      = ftz(b);
    w_a_nan  = (w_a[14:7] == 8'hFF) && (w_a[6:0] != 7'h00);
    w_b_nan  = (w_b[14:7] == 8'hFF) && (w_b[6:0] != 7'h00);
    w_a_inf  = (w_a[14:7] == 8'hFF) && (w_a[6:0] == 7'h00);
    w_b_inf  = (w_b[14:7] == 8'hFF) && (w_b[6:0] == 7'h00);
    w_a_zero = (w_a[14:0] == 15'h0000);
    w_b_zero = (w_b[14:0] == 15'h0000);

    w_big    = (w_b[14:0] > w_a[14:0]) ? w_b : w_a;
    w_small  = (w_b[14:0] > w_a[14:0]) ? w_a : w_b;
    w_diff   = w_big[14:7] - w_small[14:7];

    // Operands carry three extra LSBs: guard, round and sticky.
    w_big_al      = {2'b01, w_big[6:0], 3'b000};
    w_sm_ext      = {1'b1, w_small[6:0], 3'b000};
    w_sticky_mask = ~(11'h7FF << w_diff);
    if (w_diff >= 8'd11) begin
      w_sm_al = 12'd1;
    end else begin
      w_sm_al    = {1'b0, w_sm_ext >> w_diff};
      w_sm_al[0] = w_sm_al[0] | (|(w_sm_ext & w_sticky_mask));
    end

    if (w_big[15] == w_small[15]) w_mag = w_big_al + w_sm_al;
    else                          w_mag = w_big_al - w_sm_al;

    w_exp = signed'({2'b00, w_big[14:7]});
    if (w_mag[11]) begin
      w_mag = {1'b0, w_mag[11:2], w_mag[1] | w_mag[0]};
      w_exp = w_exp + 10'sd1;
    end

    w_lz    = 4'd0;
    w_found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!w_found && w_mag[i]) begin
        w_found = 1'b1;
        w_lz    = 4'(10 - i);
      end
    end
    w_mag = w_mag << w_lz;
    w_exp = w_exp - signed'({6'd0, w_lz});

    // A mantissa carry ripples into the exponent field: shift right plus exponent increment.
    w_rnd  = (ROUND_RNE != 0) && w_mag[2] && (w_mag[1] || w_mag[0] || w_mag[3]);
    w_body = {w_exp[7:0], w_mag[9:3]} + {14'd0, w_rnd};

    sum = 16'h0000;
    if (w_a_nan || w_b_nan)                               sum = CANONICAL_NAN;
    else if (w_a_inf && w_b_inf && (w_a[15] != w_b[15]))  sum = CANONICAL_NAN;
    else if (w_a_inf)                                     sum = w_a;
    else if (w_b_inf)                                     sum = w_b;
    else if (w_b_zero)                                    sum = w_a;
    else if (w_a_zero)                                    sum = w_b;
    else if (!w_found)                                    sum = 16'h0000;
    else if (w_exp <= 10'sd0)                             sum = 16'h0000;
    else if (w_exp >= 10'sd255)                           sum = {w_big[15], POS_INF[14:0]};
    else                                                  sum = {w_big[15], w_body};
  end

endmodule
`default_nettype wire

// File: rtl/bf16_reduce_accum.sv
`default_nettype none
// ============================================================================
// Module   : bf16_reduce_accum
// Purpose  : Per-lane BF16 reduction of a packet of beats, with beat count.
// Revision : 1.0
// ============================================================================
module bf16_reduce_accum
  import bf16_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int CNT_W     = 8,
  parameter int ROUND_RNE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LANES*16-1:0]  s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LANES*16-1:0]  m_data,
  output logic [CNT_W-1:0]     m_beats
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LANES*16-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LANES*16-1:0]  w_sum;
  logic                 w_beat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bf16_add_rne #(.ROUND_RNE(ROUND_RNE)) u_add (
      .a   (acc_q[g*16 +: 16]),
      .b   (s_data[g*16 +: 16]),
      .sum (w_sum[g*16 +: 16])
    );
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s_ready = (state_q != OUT);
    m_valid = (state_q == OUT);
    w_beat  = s_valid && s_ready;

    case (state_q)
      IDLE: begin
        if (w_beat) begin
          for (int i = 0; i < LANES; i++) acc_d[i*16 +: 16] = ftz(s_data[i*16 +: 16]);
          cnt_d   = CNT_W'(1);
          state_d = s_last ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (w_beat) begin
          acc_d = w_sum;
          // Long packets pin the count at all-ones instead of wrapping.
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (s_last) state_d = OUT;
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_data  = acc_q;
  assign m_beats = cnt_q;

endmodule
`default_nettype wire

// File: doc/bf16_reduce_accum.md
BF16_REDUCE_ACCUM -- requirements
Module: bf16_reduce_accum

Interface
REQ-001 Parameter LANES, default 4, SHALL set the number of independent BF16 lanes per beat (1..16).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the beat counter.
REQ-003 Parameter ROUND_RNE, default 1, SHALL select rounding: 1 = round-to-nearest-even, 0 = truncate toward zero.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-006 s_valid  in  1  SHALL indicate that an input beat is presented.
REQ-007 s_ready  out  1  SHALL indicate that the block accepts a beat this cycle.
REQ-008 s_data  in  LANES*16  SHALL carry BF16 operands, with lane i in bits [16i+15:16i].
REQ-009 s_last  in  1  SHALL mark the final beat of a reduction packet.
REQ-010 m_valid  out  1  SHALL indicate that a reduced result is presented.
REQ-011 m_ready  in  1  SHALL indicate that the downstream accepts the result.
REQ-012 m_data  out  LANES*16  SHALL carry the per-lane BF16 sums, using the same lane mapping as s_data.
REQ-013 m_beats  out  CNT_W  SHALL give the number of beats reduced into m_data.

Function
REQ-014 Beat transfer SHALL occur only when s_valid && s_ready; result transfer SHALL occur only when m_valid && m_ready.
REQ-015 FSM states SHALL be IDLE, ACCUM and OUT; s_ready = (state != OUT); m_valid = (state == OUT).
REQ-016 IDLE, on a beat transfer, SHALL load acc[i] = ftz(s_data lane i), set the counter to 1, and go to OUT if s_last, else to ACCUM.
REQ-017 ACCUM, on a beat transfer, SHALL set acc[i] = add(acc[i], s_data lane i), increment the counter, and go to OUT if s_last.
REQ-018 OUT, on a result transfer, SHALL go to IDLE; m_data and m_beats SHALL hold stable while m_valid && !m_ready.
REQ-019 Each accumulated beat SHALL have a 1-cycle latency: acc is updated on the clock edge that accepts the beat.
REQ-020 The last beat SHALL be accepted at edge T, with m_valid high in cycle T+1.
REQ-021 While in OUT, s_ready SHALL be 0, giving a one-cycle bubble minimum between packets; there is no overlap.
REQ-022 The counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 Add: inputs with exp==0 SHALL be flushed to signed zero (FTZ); results with exp<=0 after normalisation SHALL be flushed to +0.
REQ-024 Add: magnitude ordering, exact alignment with guard and round bits plus a sticky OR of all shifted-out bits, and leading-zero normalisation SHALL be applied.
REQ-025 Rounding SHALL follow ROUND_RNE; a rounding carry that overflows the mantissa SHALL shift right and increment the exponent.
REQ-026 A final exponent >= 255 SHALL produce signed infinity (sign << 15 | 0x7F80).
REQ-027 Special cases SHALL follow priority NaN > inf-inf > inf > zero > normal:
  - any NaN -> 0x7FC0;
  - +inf + -inf -> 0x7FC0;
  - inf + finite -> the inf;
  - x + 0 -> x (after FTZ);
  - exact cancellation -> 0x0000.
REQ-028 A NaN SHALL remain sticky: once acc[i] is NaN, it stays 0x7FC0 until the packet ends.
REQ-029 Lanes SHALL be fully independent; a special value in one lane SHALL NOT affect the others.

Reset
REQ-030 rst high at any clock edge SHALL force: state = IDLE, acc = 0, counter = 0, m_valid = 0, s_ready = 1 (next cycle).
REQ-031 rst mid-packet or in OUT SHALL discard the partial or pending result without emitting it.

Structure
REQ-032 Package bf16_pkg SHALL hold the typedef bf16_t (16-bit) and the constants CANONICAL_NAN = 0x7FC0, POS_INF = 0x7F80, NEG_INF = 0xFF80 and BF16_BIAS = 127.
REQ-033 A combinational sub-module bf16_add_rne (a, b, parameter ROUND_RNE -> sum) SHALL be instantiated LANES times via generate.
REQ-034 All sequential logic (FSM, acc registers, counter) SHALL reside in bf16_reduce_accum.

Verification
REQ-035 LANES=4, three beats all lanes {0x3F80, 0x4000, 0x4040}, last on the third -> m_data lanes all 0x40C0 (6.0), m_beats = 3.
REQ-036 ROUND_RNE=1: 0x3F81 + 0x3B80 (tie) -> 0x3F82; 0x3F80 + 0x3B80 -> 0x3F80; ROUND_RNE=0: 0x3F81 + 0x3B80 -> 0x3F81.
REQ-037 Per-lane specials in one packet -> 0x7F7F + 0x7F7F = 0x7F80, 0x7F80 + 0xFF80 = 0x7FC0, 0x3F80 + 0xBF80 = 0x0000, 0x7FC1 then 0x3F80 = 0x7FC0, with each lane independent.
REQ-038 Single-beat packet (s_last on the first beat) 0x4049 -> m_valid the next cycle, m_data = 0x4049, m_beats = 1.
REQ-039 m_ready held low for 5 cycles in OUT -> m_data stable and s_ready = 0 throughout; after acceptance, IDLE and s_ready = 1.
REQ-040 rst asserted after 2 of 4 beats -> no m_valid; the next packet 0x3F80 x2 -> 0x4000 with m_beats = 2. Also: 300 beats with CNT_W=8 -> m_beats = 255.
